fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: a PC register issues word reads to memory and pushes
// {pc, data} into a small in-order queue that the decode stage drains.
module fetch_unit #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int RESET_VECTOR = 0,
   parameter int STEP         = 1,
   parameter int DEPTH        = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        fetch_enable,
   output logic [ADDR_WIDTH-1:0]       mem_address,
   output logic                        mem_read,
   input  logic [DATA_WIDTH-1:0]       mem_data,
   input  logic                        redirect,
   input  logic [ADDR_WIDTH-1:0]       redirect_target,
   output logic                        instr_valid,
   input  logic                        instr_ready,
   output logic [DATA_WIDTH-1:0]       instr_out,
   output logic [ADDR_WIDTH-1:0]       instr_pc,
   output logic [$clog2(DEPTH):0]      fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] pc;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
   logic                  full;
   logic                  push;
   logic                  pop;

   // Handshake: the head moves on a rising edge only when instr_valid and
   // instr_ready are both high; while valid and not ready the head holds.
   assign full        = (count == CNT_W'(DEPTH));
   assign push        = fetch_enable && !full && !redirect;
   assign pop         = instr_valid && instr_ready;
   assign mem_read    = push;
   assign mem_address = pc;
   assign instr_valid = (count != '0);
   assign instr_out   = data_mem[rd_ptr];
   assign instr_pc    = pc_mem[rd_ptr];
   assign fifo_count  = count;

   always_ff @(posedge clock) begin
      if (!reset) begin
         pc     <= ADDR_WIDTH'(RESET_VECTOR);
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         pc     <= redirect_target;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            pc     <= pc + ADDR_WIDTH'(STEP);
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is only invalidated by reset/redirect, never cleared.
   always_ff @(posedge clock) begin
      if (reset && push) begin
         data_mem[wr_ptr] <= mem_data;
         pc_mem[wr_ptr]   <= pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit; memory returns 10*address.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_enable;
   logic [31:0] mem_address;
   logic        mem_read;
   logic [31:0] mem_data;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic [2:0]  fifo_count;

   logic       w_reset;
   logic [3:0] w_mem_address;
   logic       w_mem_read;
   logic [7:0] w_mem_data;
   logic       w_instr_valid;
   logic [7:0] w_instr_out;
   logic [3:0] w_instr_pc;
   logic [2:0] w_fifo_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   assign mem_data   = mem_address * 32'd10;
   assign w_mem_data = 8'(w_mem_address) * 8'd10;

   fetch_unit dut (
      .clock(clock), .reset(reset), .fetch_enable(fetch_enable),
      .mem_address(mem_address), .mem_read(mem_read), .mem_data(mem_data),
      .redirect(redirect), .redirect_target(redirect_target),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_out(instr_out), .instr_pc(instr_pc), .fifo_count(fifo_count)
   );

   fetch_unit #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RESET_VECTOR(14)) dut_w (
      .clock(clock), .reset(w_reset), .fetch_enable(1'b1),
      .mem_address(w_mem_address), .mem_read(w_mem_read), .mem_data(w_mem_data),
      .redirect(1'b0), .redirect_target(4'd0),
      .instr_valid(w_instr_valid), .instr_ready(1'b1),
      .instr_out(w_instr_out), .instr_pc(w_instr_pc), .fifo_count(w_fifo_count)
   );

   typedef struct {
      logic        rst;
      logic        fe;
      logic        rdy;
      logic        rd;
      logic [31:0] tgt;
      logic [31:0] addr;
      logic        mr;
      logic        vld;
      logic [31:0] hpc;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic fe, logic rdy, logic rd, int tgt,
                               int addr, logic mr, logic vld, int hpc, int cnt);
      vec_t v;
      v.rst = rst; v.fe = fe; v.rdy = rdy; v.rd = rd; v.tgt = 32'(tgt);
      v.addr = 32'(addr); v.mr = mr; v.vld = vld; v.hpc = 32'(hpc); v.cnt = 3'(cnt);
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // rst fe rdy rd tgt | addr mr vld hpc cnt
      vecs.push_back(mk(1, 1, 1, 0, 0,    0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0,    1, 1, 1, 0, 1));
      vecs.push_back(mk(1, 1, 1, 0, 0,    2, 1, 1, 1, 1));
      vecs.push_back(mk(1, 1, 1, 0, 0,    3, 1, 1, 2, 1));
      vecs.push_back(mk(0, 1, 1, 0, 0,    4, 1, 1, 3, 1));
      vecs.push_back(mk(1, 1, 0, 0, 0,    0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0,    1, 1, 1, 0, 1));
      vecs.push_back(mk(1, 1, 0, 0, 0,    2, 1, 1, 0, 2));
      vecs.push_back(mk(1, 1, 0, 0, 0,    3, 1, 1, 0, 3));
      vecs.push_back(mk(1, 1, 0, 0, 0,    4, 0, 1, 0, 4));
      vecs.push_back(mk(1, 1, 0, 0, 0,    4, 0, 1, 0, 4));
      vecs.push_back(mk(1, 1, 1, 0, 0,    4, 0, 1, 0, 4));
      vecs.push_back(mk(1, 1, 0, 0, 0,    4, 1, 1, 1, 3));
      vecs.push_back(mk(1, 1, 1, 0, 0,    5, 0, 1, 1, 4));
      vecs.push_back(mk(1, 1, 1, 1, 100,  5, 0, 1, 2, 3));
      vecs.push_back(mk(1, 1, 1, 0, 0,  100, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0,  101, 1, 1, 100, 1));
      vecs.push_back(mk(1, 1, 1, 0, 0,  102, 1, 1, 101, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0,  103, 0, 1, 102, 1));
      vecs.push_back(mk(1, 0, 1, 0, 0,  103, 0, 1, 102, 1));
      vecs.push_back(mk(1, 0, 1, 0, 0,  103, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 50, 103, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0));

      reset = 1'b0; w_reset = 1'b0; fetch_enable = 1'b0; instr_ready = 1'b0;
      redirect = 1'b0; redirect_target = '0;
      tick();
      tick();
      reset = 1'b1;

      foreach (vecs[i]) begin
         reset = vecs[i].rst; fetch_enable = vecs[i].fe; instr_ready = vecs[i].rdy;
         redirect = vecs[i].rd; redirect_target = vecs[i].tgt;
         #1;
         check($sformatf("v%0d mem_address", i), 64'(mem_address), 64'(vecs[i].addr));
         check($sformatf("v%0d mem_read", i), 64'(mem_read), 64'(vecs[i].mr));
         check($sformatf("v%0d instr_valid", i), 64'(instr_valid), 64'(vecs[i].vld));
         check($sformatf("v%0d fifo_count", i), 64'(fifo_count), 64'(vecs[i].cnt));
         if (vecs[i].vld) begin
            check($sformatf("v%0d instr_pc", i), 64'(instr_pc), 64'(vecs[i].hpc));
            check($sformatf("v%0d instr_out", i), 64'(instr_out), 64'(vecs[i].hpc * 10));
         end
         tick();
      end
      reset = 1'b1; redirect = 1'b0;

      // Reset mid-operation with PC = 9 and two queued entries.
      fetch_enable = 1'b1; instr_ready = 1'b0; redirect = 1'b1; redirect_target = 32'd7;
      tick();
      redirect = 1'b0;
      tick();
      tick();
      fetch_enable = 1'b0;
      #1;
      check("mid pc before reset", 64'(mem_address), 64'd9);
      check("mid count before reset", 64'(fifo_count), 64'd2);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check("mid pc after reset", 64'(mem_address), 64'd0);
      check("mid count after reset", 64'(fifo_count), 64'd0);
      check("mid valid after reset", 64'(instr_valid), 64'd0);

      // A reset pulse between edges must be ignored.
      fetch_enable = 1'b1;
      tick();
      tick();
      fetch_enable = 1'b0;
      #1 reset = 1'b0;
      #2 reset = 1'b1;
      tick();
      check("glitch pc", 64'(mem_address), 64'd2);
      check("glitch count", 64'(fifo_count), 64'd2);
      check("glitch valid", 64'(instr_valid), 64'd1);
      check("glitch head pc", 64'(instr_pc), 64'd0);

      // PC wrap on a 4-bit address space starting at 14.
      tick();
      w_reset = 1'b1;
      #1;
      check("wrap first addr", 64'(w_mem_address), 64'd14);
      check("wrap first valid", 64'(w_instr_valid), 64'd0);
      begin
         logic [3:0] exp_pc [4];
         exp_pc[0] = 4'd14; exp_pc[1] = 4'd15; exp_pc[2] = 4'd0; exp_pc[3] = 4'd1;
         for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("wrap%0d instr_pc", k), 64'(w_instr_pc), 64'(exp_pc[k]));
            check($sformatf("wrap%0d instr_out", k), 64'(w_instr_out), 64'(exp_pc[k]) * 10);
            check($sformatf("wrap%0d count", k), 64'(w_fifo_count), 64'd1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
